activation_drain: RTL and testbench
===================================

ACTIVATION_DRAIN -- requirements
Module: activation_drain

Interface
REQ-001 The block SHALL have parameter N, default 16, signed fixed-point element width.
REQ-002 The block SHALL have parameter AROW, default 4, result rows.
REQ-003 The block SHALL have parameter BCOL, default 4, result columns.
REQ-004 The block SHALL have parameter FIXED_POINT_POSITION, default 4, fractional bits; informational only, no rescaling in this block.
REQ-005 The block SHALL have parameter LATENCY, default 10, cycles from the accepted start to the sys_array sample; legal range 1 to 255.
REQ-006 The block SHALL have parameter RELU_EN, default 1; 1 enables ReLU, 0 bypasses it.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit, synchronous active-low reset (0 = reset).
REQ-009 The block SHALL have port valid, input, 1 bit, start pulse, tied to the same valid that launches the upstream systolic array.
REQ-010 The block SHALL have port sys_array, input, [AROW][BCOL][N], packed signed result matrix from the systolic array.
REQ-011 The block SHALL have port bias, input, [BCOL][N], per-column signed bias, sampled at capture.
REQ-012 The block SHALL have port out_data, output, [BCOL][N], one processed result row.
REQ-013 The block SHALL have port out_row, output, clog2(AROW) bits, index of the row on out_data.
REQ-014 The block SHALL have port out_valid, output, 1 bit, out_data is valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit, consumer accepts the row.
REQ-016 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-017 The block SHALL have port overrun, output, 1 bit, sticky flag: a start was dropped.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, WAIT, DRAIN.
REQ-019 In IDLE, valid=1 at an edge SHALL load the counter with LATENCY-1 and move to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each edge while non-zero; an edge with counter==0 SHALL capture and move to DRAIN.
REQ-021 Capture SHALL therefore occur exactly LATENCY edges after the edge that accepted valid.
REQ-022 At capture, each element SHALL become sat_N(sys_array[r][c] + bias[c]), computed at N+1 bits and clamped to the range -2^(N-1) to 2^(N-1)-1.
REQ-023 If RELU_EN=1, negative saturated values SHALL become 0 at capture.
REQ-024 Processed results SHALL be held in an internal AROW x BCOL register bank; sys_array changes after capture SHALL have no effect.
REQ-025 In DRAIN, out_valid SHALL be 1, with out_data = bank row r and out_row = r; r starts at 0 on entry.
REQ-026 A transfer SHALL occur at an edge with out_valid=1 and out_ready=1; r increments on each transfer.
REQ-027 The transfer of row AROW-1 SHALL return the FSM to IDLE, with out_valid=0 from the next cycle.
REQ-028 With out_ready=0, out_data and out_row SHALL remain stable; the block SHALL impose no timeout.
REQ-029 valid=1 in WAIT or DRAIN, including the final-transfer edge, SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-030 out_valid SHALL never assert in IDLE or WAIT.

Reset
REQ-031 rst=0 at an edge SHALL force IDLE and set out_valid=0, busy=0, overrun=0, out_row=0, out_data=0, counter=0, and zero the register bank.
REQ-032 Reset SHALL take priority over valid and any transfer on the same edge, and SHALL abort WAIT or DRAIN without emitting a row.

Verification
REQ-033 Bench: LATENCY=10, bias=0, out_ready=1; valid pulse at edge k with sys_array row0 = 4000, 4160, 4320, 4480 (Q4: 250, 260, 270, 280) -> capture at edge k+10; rows 0-3 on 4 consecutive cycles; row0 bit-exact.
REQ-034 Bench: element -32 with bias 0 -> 0 with RELU_EN=1, and -32 with RELU_EN=0.
REQ-035 Bench: 32000 + bias 1000 -> 32767; -32000 + bias -1000 -> -32768 with RELU_EN=0, and 0 with RELU_EN=1.
REQ-036 Bench: out_ready held low 3 cycles on row 1 -> out_data and out_row stable; row 1 transfers on the first edge with out_ready high; busy stays high throughout.
REQ-037 Bench: valid pulsed during WAIT and during the final-transfer cycle -> no extra capture, overrun=1, FSM reaches IDLE after 4 transfers.
REQ-038 Bench: rst=0 at edge k+5 of WAIT -> IDLE, all outputs 0, no row emitted; a fresh valid then completes normally.

Source files
------------

// File: rtl/activation_drain.sv
// -----------------------------------------------------------------------------
// activation_drain
//
// Captures the result matrix of a systolic array a fixed number of cycles after
// the start pulse that launched it, adds a per-column bias with saturation,
// optionally applies ReLU, and then streams the processed matrix out one row
// at a time over a valid/ready handshake.
//
// Parameters
//   N                    signed fixed-point element width
//   AROW                 result rows (2 or more)
//   BCOL                 result columns
//   FIXED_POINT_POSITION fractional bits (informational, no rescaling here)
//   LATENCY              edges from accepted start to capture (1..255)
//   RELU_EN              1 = clamp negative results to 0, 0 = bypass
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-low reset
//   valid      start pulse (same pulse that launches the systolic array)
//   sys_array  packed signed result matrix [AROW][BCOL][N]
//   bias       per-column signed bias [BCOL][N], sampled at capture
//   out_data   one processed row [BCOL][N]
//   out_row    index of the row on out_data
//   out_valid  out_data holds a row waiting for transfer
//   out_ready  consumer accepts the row
//   busy       block is not idle
//   overrun    sticky: a start pulse arrived while busy and was dropped
// -----------------------------------------------------------------------------
module activation_drain #(
   parameter  int N                    = 16,
   parameter  int AROW                 = 4,
   parameter  int BCOL                 = 4,
   parameter  int FIXED_POINT_POSITION = 4,
   parameter  int LATENCY              = 10,
   parameter  int RELU_EN              = 1,
   localparam int ROW_W                = (AROW > 1) ? $clog2(AROW) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              valid,
   input  logic [AROW-1:0][BCOL-1:0][N-1:0]  sys_array,
   input  logic [BCOL-1:0][N-1:0]            bias,
   output logic [BCOL-1:0][N-1:0]            out_data,
   output logic [ROW_W-1:0]                  out_row,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              busy,
   output logic                              overrun
);

   // The binary point position does not affect this block; it is carried
   // only so the parameter set matches the surrounding datapath.
   localparam int unused_fxp = FIXED_POINT_POSITION;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRAIN
   } state_t;

   state_t                           state;
   state_t                           state_nxt;
   logic [7:0]                       count;
   logic [ROW_W-1:0]                 row;
   logic [AROW-1:0][BCOL-1:0][N-1:0] bank;
   logic [AROW-1:0][BCOL-1:0][N-1:0] processed;
   logic                             last_row;

   // Bias add at N+1 bits, clamp to the N-bit signed range, optional ReLU.
   // The sum of two N-bit signed values always fits in N+1 bits, so it is in
   // range exactly when its top two bits agree.
   function automatic logic [N-1:0] sat_relu(input logic [N-1:0] x,
                                             input logic [N-1:0] b);
      logic [N:0]   sum;
      logic [N-1:0] res;
      sum = {x[N-1], x} + {b[N-1], b};
      if (sum[N] != sum[N-1])
         res = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else
         res = sum[N-1:0];
      if (RELU_EN != 0 && res[N-1])
         res = '0;
      return res;
   endfunction

   always_comb begin
      processed = '0;
      for (int r = 0; r < AROW; r++)
         for (int c = 0; c < BCOL; c++)
            processed[r][c] = sat_relu(sys_array[r][c], bias[c]);
   end

   assign last_row = (row == ROW_W'(AROW - 1));

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid)                 state_nxt = WAIT;
         WAIT:    if (count == 8'd0)         state_nxt = DRAIN;
         DRAIN:   if (out_ready && last_row) state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: the result bank is cleared on reset because out_data must read
   // zero straight out of reset; a plain storage array would normally skip it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count   <= '0;
         row     <= '0;
         bank    <= '0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid)
                  count <= 8'(LATENCY - 1);
            end
            WAIT: begin
               if (count != 8'd0) begin
                  count <= count - 8'd1;
               end else begin
                  bank <= processed;
                  row  <= '0;
               end
            end
            DRAIN: begin
               // Wrap explicitly so a non-power-of-two AROW still restarts at 0.
               if (out_ready)
                  row <= last_row ? '0 : row + 1'b1;
            end
            default: ;
         endcase

         // A start while busy (including the final-transfer edge) is dropped.
         if (valid && state != IDLE)
            overrun <= 1'b1;
      end
   end

   assign out_valid = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign out_row   = row;
   assign out_data  = bank[row];

endmodule

// File: tb/tb_activation_drain.sv
// -----------------------------------------------------------------------------
// tb_activation_drain
//
// Drives two instances of activation_drain from the same stimulus, one with
// ReLU enabled and one with it bypassed, and compares both against an
// arithmetic reference model of the bias/saturate/ReLU rule and of the
// capture timing and row handshake.
// -----------------------------------------------------------------------------
module tb_activation_drain;

   localparam int N    = 16;
   localparam int AROW = 4;
   localparam int BCOL = 4;
   localparam int LAT  = 10;
   localparam int W    = BCOL * N;

   typedef logic [BCOL-1:0][N-1:0] row_t;

   typedef struct {
      int a;
      int b;
      int e_relu;
      int e_lin;
   } vec_t;

   logic                             clk = 1'b0;
   logic                             rst;
   logic                             valid;
   logic                             out_ready;
   logic [AROW-1:0][BCOL-1:0][N-1:0] sys_array;
   row_t                             bias;
   row_t                             data_r, data_l;
   logic [1:0]                       row_r, row_l;
   logic                             vld_r, vld_l, bz_r, bz_l, ovf_r, ovf_l;

   int   checks = 0;
   int   errors = 0;
   bit   ov_exp = 1'b0;
   row_t exp_r [AROW];
   row_t exp_l [AROW];
   vec_t vecs  [8];

   always #5 clk = ~clk;

   activation_drain #(
      .N(N), .AROW(AROW), .BCOL(BCOL), .FIXED_POINT_POSITION(4),
      .LATENCY(LAT), .RELU_EN(1)
   ) u_relu (
      .clk(clk), .rst(rst), .valid(valid), .sys_array(sys_array), .bias(bias),
      .out_data(data_r), .out_row(row_r), .out_valid(vld_r),
      .out_ready(out_ready), .busy(bz_r), .overrun(ovf_r)
   );

   activation_drain #(
      .N(N), .AROW(AROW), .BCOL(BCOL), .FIXED_POINT_POSITION(4),
      .LATENCY(LAT), .RELU_EN(0)
   ) u_lin (
      .clk(clk), .rst(rst), .valid(valid), .sys_array(sys_array), .bias(bias),
      .out_data(data_l), .out_row(row_l), .out_valid(vld_l),
      .out_ready(out_ready), .busy(bz_l), .overrun(ovf_l)
   );

   // Reference rule: plain integer sum, clamp to the N-bit signed range, ReLU.
   function automatic int model(input int a, input int b, input bit relu);
      int s, hi, lo;
      hi = (1 <<< (N - 1)) - 1;
      lo = -(1 <<< (N - 1));
      s  = a + b;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   function automatic logic [N-1:0] to_n(input int v);
      return v[N-1:0];
   endfunction

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_all();
      int a, b;
      for (int r = 0; r < AROW; r++)
         for (int c = 0; c < BCOL; c++) begin
            a = int'($signed(sys_array[r][c]));
            b = int'($signed(bias[c]));
            exp_r[r][c] = to_n(model(a, b, 1'b1));
            exp_l[r][c] = to_n(model(a, b, 1'b0));
         end
   endtask

   task automatic randomize_inputs();
      for (int r = 0; r < AROW; r++)
         sys_array[r] = {$urandom(), $urandom()};
      bias = {$urandom(), $urandom()};
   endtask

   // One full transaction: start pulse, LATENCY-edge wait, AROW-row drain.
   // mode 0: always ready; 1: random stalls; 2: three-cycle stall on row 1.
   // pw/pf inject a start pulse during WAIT / on the final-transfer edge.
   task automatic run_txn(input int mode, input bit pw, input bit pf,
                          input bit use_model);
      int r, stalls;
      bit rdy, seen;
      if (use_model) model_all();
      out_ready = 1'b1;
      check("idle_before_start", W'({vld_r, vld_l, bz_r, bz_l}), W'(4'b0000));
      valid = 1'b1;
      tick();
      valid = 1'b0;
      check("wait_status", W'({vld_r, vld_l, bz_r, bz_l}), W'(4'b0011));
      for (int i = 1; i < LAT; i++) begin
         valid = pw && (i == 3);
         if (valid) ov_exp = 1'b1;
         tick();
         valid = 1'b0;
         check("wait_status", W'({vld_r, vld_l, bz_r, bz_l}), W'(4'b0011));
      end
      tick();  // capture edge
      r = 0;
      stalls = 0;
      while (r < AROW) begin
         case (mode)
            1:       rdy = (stalls >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
            2:       rdy = !(r == 1 && stalls < 3);
            default: rdy = 1'b1;
         endcase
         out_ready = rdy;
         // Inputs after capture must not disturb the held results.
         randomize_inputs();
         valid = pf && (r == AROW - 1) && rdy;
         if (valid) ov_exp = 1'b1;
         check("drain_status", W'({vld_r, vld_l, bz_r, bz_l}), W'(4'b1111));
         check("out_row_relu", W'(row_r), W'(r));
         check("out_row_lin", W'(row_l), W'(r));
         check("out_data_relu", data_r, exp_r[r]);
         check("out_data_lin", data_l, exp_l[r]);
         tick();
         valid = 1'b0;
         if (rdy) begin
            r++;
            stalls = 0;
         end else begin
            stalls++;
         end
      end
      check("idle_after_drain", W'({vld_r, vld_l, bz_r, bz_l}), W'(4'b0000));
      check("overrun", W'({ovf_r, ovf_l}), W'({ov_exp, ov_exp}));
      if (pw || pf) begin
         seen = 1'b0;
         repeat (15) begin
            tick();
            seen |= vld_r | vld_l | bz_r | bz_l;
         end
         check("no_extra_capture", W'(seen), W'(1'b0));
      end
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{a:   4000, b:      0, e_relu:  4000, e_lin:   4000};
      vecs[1] = '{a:    -32, b:      0, e_relu:     0, e_lin:    -32};
      vecs[2] = '{a:  32000, b:   1000, e_relu: 32767, e_lin:  32767};
      vecs[3] = '{a: -32000, b:  -1000, e_relu:     0, e_lin: -32768};
      vecs[4] = '{a:    100, b:   -200, e_relu:     0, e_lin:   -100};
      vecs[5] = '{a:  20000, b:  12767, e_relu: 32767, e_lin:  32767};
      vecs[6] = '{a: -32768, b:      0, e_relu:     0, e_lin: -32768};
      vecs[7] = '{a: -20000, b: -12769, e_relu:     0, e_lin: -32768};

      rst       = 1'b0;
      valid     = 1'b0;
      out_ready = 1'b0;
      sys_array = '0;
      bias      = '0;
      tick();
      tick();
      check("reset_status", W'({vld_r, vld_l, bz_r, bz_l, ovf_r, ovf_l}), W'(6'b0));
      check("reset_row", W'({row_r, row_l}), W'(4'b0));
      check("reset_data_relu", data_r, '0);
      check("reset_data_lin", data_l, '0);
      rst = 1'b1;
      tick();

      // Element rule table: every element and every bias set to one vector.
      for (int v = 0; v < 8; v++) begin
         for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++)
               sys_array[r][c] = to_n(vecs[v].a);
         for (int c = 0; c < BCOL; c++)
            bias[c] = to_n(vecs[v].b);
         for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) begin
               exp_r[r][c] = to_n(vecs[v].e_relu);
               exp_l[r][c] = to_n(vecs[v].e_lin);
            end
         run_txn(0, 1'b0, 1'b0, 1'b0);
      end

      // Q4 reference row, zero bias, continuous ready.
      randomize_inputs();
      bias = '0;
      sys_array[0][0] = to_n(4000);
      sys_array[0][1] = to_n(4160);
      sys_array[0][2] = to_n(4320);
      sys_array[0][3] = to_n(4480);
      run_txn(0, 1'b0, 1'b0, 1'b1);

      // Back-pressure on row 1.
      randomize_inputs();
      run_txn(2, 1'b0, 1'b0, 1'b1);

      // Random matrices, biases and stalls.
      for (int t = 0; t < 12; t++) begin
         randomize_inputs();
         run_txn(1, 1'b0, 1'b0, 1'b1);
      end

      // Start pulses while busy are dropped and flagged.
      randomize_inputs();
      run_txn(0, 1'b1, 1'b1, 1'b1);

      // Reset in the middle of WAIT, with a start pulse on the same edge.
      randomize_inputs();
      out_ready = 1'b1;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (4) tick();
      rst   = 1'b0;
      valid = 1'b1;
      tick();
      rst    = 1'b1;
      valid  = 1'b0;
      ov_exp = 1'b0;
      check("wait_reset_status", W'({vld_r, vld_l, bz_r, bz_l, ovf_r, ovf_l}), W'(6'b0));
      check("wait_reset_row", W'({row_r, row_l}), W'(4'b0));
      check("wait_reset_data_relu", data_r, '0);
      check("wait_reset_data_lin", data_l, '0);
      begin
         bit seen;
         seen = 1'b0;
         repeat (15) begin
            tick();
            seen |= vld_r | vld_l | bz_r | bz_l;
         end
         check("no_row_after_reset", W'(seen), W'(1'b0));
      end
      randomize_inputs();
      run_txn(1, 1'b0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
